writeback_unit: RTL
===================

// Module: writeback_unit
// PURPOSE
//  Parametrised W stage: stage register M->W plus load-data extraction for DATA_W 32/64.
//  Adds a load-response FSM so multi-cycle dbus loads block retirement instead of assuming data next cycle.
//  Buffers a returned load word while W is stalled, and drains responses of flushed loads.
//  Sits between the memory stage and the register file; WaitReqW feeds the hazard unit.
// PARAMETERS
//  DATA_W     32  datapath/dbus data width; legal values 32 or 64
//  ADDR_W     32  PC and effective-address width
//  REGIDX_W   5   register index width
// PORTS
//  clk          in   1         clock, all state on rising edge
//  resetn       in   1         synchronous active-low reset
//  StallW       in   1         hold W register (from hazard unit)
//  FlushW       in   1         squash W instruction (from hazard unit)
//  dresp_data_ok in  1         dbus response valid this cycle
//  dresp_data   in   DATA_W    dbus read data, full aligned word
//  PCM          in   ADDR_W    PC of M instruction
//  ALUOutM      in   DATA_W    ALU result / effective address
//  WriteRegM    in   REGIDX_W  destination register
//  RegWriteM    in   1         M instruction writes a register
//  MemtoRegM    in   1         M instruction is a load
//  SizeM        in   2         0=1B 1=2B 2=4B 3=8B
//  SignedM      in   1         sign-extend load result
//  PCW          out  ADDR_W    PC of W instruction
//  ResultW      out  DATA_W    writeback value
//  WriteRegW    out  REGIDX_W  destination register
//  RegWriteW    out  1         register-file write enable, gated by load completion
//  WaitReqW     out  1         W cannot retire; hazard unit must stall W and upstream
// BEHAVIOUR
//  Register update priority per edge: ~resetn > FlushW > StallW > capture M fields.
//  Reset/flush: PCW, ALUOutW, WriteRegW, SizeW, SignedW = 0; RegWrite/MemtoReg regs = 0; ResultW = 0.
//  FSM states IDLE, WAIT, HELD, DRAIN; reset -> IDLE; read buffer RBUF (DATA_W) reset 0.
//   IDLE : capture with MemtoRegM=1 -> WAIT.
//   WAIT : data_ok & ~StallW -> retire same cycle; next IDLE, or WAIT if new load captured.
//          data_ok & StallW -> RBUF<=dresp_data, -> HELD. no data_ok -> stay.
//   HELD : result from RBUF; ~StallW -> retire; -> IDLE or WAIT as above.
//   DRAIN: outstanding response of a flushed load; next data_ok discarded -> IDLE.
//  FlushW in WAIT with data_ok=0 -> DRAIN; FlushW in WAIT with data_ok=1 -> IDLE (data dropped).
//  FlushW in HELD/IDLE -> IDLE. FlushW in DRAIN -> stay DRAIN. reset mid-load -> IDLE, response not drained.
//  WaitReqW = (WAIT & ~data_ok) | DRAIN; combinational, no register.
//  RegWriteW = RegWrite reg & ~(MemtoReg reg & WaitReqW); never 1 in DRAIN.
//  Load source word LW = (WAIT) ? dresp_data : RBUF (zero-latency bypass on data_ok).
//  Extraction: OFF = ALUOutW[log2(DATA_W/8)-1:0] aligned down to size; lane = LW[8*OFF +: 8<<Size].
//  Result = lane zero- or sign-extended (SignedW & lane MSB) to DATA_W.
//  DATA_W=32: Size=3 treated as Size=2; Size=2 with DATA_W=32 ignores sign (full word).
//  Non-load: ResultW = ALUOutW, combinational from W register, no dependency on FSM.
//  dresp_data_ok in IDLE or HELD is ignored (protocol error; no state change).
// TESTING
//  ALU op: RegWriteM=1, ALUOutM=0x1234_5678, capture -> next cycle ResultW=0x1234_5678, RegWriteW=1, WaitReqW=0.
//  LB signed, DATA_W=32, addr low bits 3, data 0x80FF_FF00 arrives 2 cycles late -> WaitReqW=1 two cycles, then ResultW=0xFFFF_FF80, RegWriteW=1.
//  LHU, data_ok while StallW=1, data 0xBEEF_1234 addr[1]=1 -> HELD, dresp changes to 0; on StallW=0 ResultW=0x0000_BEEF.
//  LD signed DATA_W=64 offset 0, data 0x8000_0000_0000_0001 -> ResultW=0x8000_0000_0000_0001; LW signed offset 4 -> 0xFFFF_FFFF_8000_0000.
//  FlushW in WAIT, data_ok 3 cycles later (0xDEAD) -> DRAIN, WaitReqW=1 until data_ok, RegWriteW=0 throughout, then IDLE.
//  resetn=0 during WAIT -> next cycle IDLE, all outputs 0, WaitReqW=0.

Source files
------------

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
//
// W pipeline stage. Holds the M->W stage register, turns the raw dbus read
// word into the architectural load result (byte/half/word/dword lane select
// with zero/sign extension), and runs a small load-response FSM. The FSM lets
// a dbus load take any number of cycles: W refuses to retire until the
// response arrives. If W is stalled when the data shows up, the word is
// parked in a read buffer. If a load is flushed before its data returns, the
// response is swallowed later.
//
// Parameters
//   DATA_W    datapath / dbus data width (32 or 64)
//   ADDR_W    PC and effective-address width
//   REGIDX_W  register index width
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   resetn         in   synchronous active-low reset
//   StallW         in   hold the W register (hazard unit)
//   FlushW         in   squash the W instruction (hazard unit)
//   dresp_data_ok  in   dbus response valid this cycle
//   dresp_data     in   dbus read data, full aligned word
//   PCM            in   PC of the M instruction
//   ALUOutM        in   ALU result / effective address of M
//   WriteRegM      in   destination register of M
//   RegWriteM      in   M writes a register
//   MemtoRegM      in   M is a load
//   SizeM          in   access size: 0=1B 1=2B 2=4B 3=8B
//   SignedM        in   sign-extend the load result
//   PCW            out  PC of the W instruction
//   ResultW        out  writeback value
//   WriteRegW      out  destination register of W
//   RegWriteW      out  register-file write enable, held off until load data
//   WaitReqW       out  W cannot retire this cycle (to hazard unit)
// ---------------------------------------------------------------------------
module writeback_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REGIDX_W = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                StallW,
  input  logic                FlushW,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data,
  input  logic [ADDR_W-1:0]   PCM,
  input  logic [DATA_W-1:0]   ALUOutM,
  input  logic [REGIDX_W-1:0] WriteRegM,
  input  logic                RegWriteM,
  input  logic                MemtoRegM,
  input  logic [1:0]          SizeM,
  input  logic                SignedM,
  output logic [ADDR_W-1:0]   PCW,
  output logic [DATA_W-1:0]   ResultW,
  output logic [REGIDX_W-1:0] WriteRegW,
  output logic                RegWriteW,
  output logic                WaitReqW
);

  // Number of address bits that select a byte within one dbus word.
  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // no load outstanding in W
    S_WAIT  = 2'd1,  // load in W, response not yet seen
    S_HELD  = 2'd2,  // response captured in rbuf_q, W stalled
    S_DRAIN = 2'd3   // flushed load still owes a response
  } state_e;

  // -------------------------------------------------------------------------
  // M->W stage register
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   aluout_q;
  logic [REGIDX_W-1:0] wreg_q;
  logic                regwrite_q;
  logic                memtoreg_q;
  logic [1:0]          size_q;
  logic                signed_q;

  always_ff @(posedge clk) begin
    if (!resetn || FlushW) begin
      pc_q       <= '0;
      aluout_q   <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
    end else if (!StallW) begin
      pc_q       <= PCM;
      aluout_q   <= ALUOutM;
      wreg_q     <= WriteRegM;
      regwrite_q <= RegWriteM;
      memtoreg_q <= MemtoRegM;
      size_q     <= SizeM;
      signed_q   <= SignedM;
    end
  end

  // -------------------------------------------------------------------------
  // Load-response FSM and read buffer
  // -------------------------------------------------------------------------
  state_e              state_q;
  logic [DATA_W-1:0]   rbuf_q;

  // Whenever W retires with no stall/flush, the stage register takes the M
  // instruction on the same edge, so a load in M goes straight to WAIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // A response still in flight is not drained: the bus is assumed to be
      // reset along with this stage.
      state_q <= S_IDLE;
      rbuf_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Responses here are protocol errors and are ignored.
          if (!FlushW && !StallW && MemtoRegM) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (FlushW) begin
            // Data arriving together with the flush is simply dropped;
            // otherwise the late response must still be absorbed.
            state_q <= dresp_data_ok ? S_IDLE : S_DRAIN;
          end else if (dresp_data_ok) begin
            if (StallW) begin
              rbuf_q  <= dresp_data;
              state_q <= S_HELD;
            end else begin
              state_q <= MemtoRegM ? S_WAIT : S_IDLE;
            end
          end
        end
        S_HELD: begin
          if (FlushW) begin
            state_q <= S_IDLE;
          end else if (!StallW) begin
            state_q <= MemtoRegM ? S_WAIT : S_IDLE;
          end
        end
        S_DRAIN: begin
          // Flushes do not cancel the debt; only the response does.
          if (dresp_data_ok) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Load data extraction
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_result;
  logic [OFF_W-1:0]  ld_off;
  logic [1:0]        size_eff;

  // In WAIT the response is used the cycle it arrives; after that it lives in
  // the read buffer.
  assign load_word = (state_q == S_WAIT) ? dresp_data : rbuf_q;

  always_comb begin
    size_eff = size_q;
    // A 32-bit bus has no doubleword accesses; treat them as words.
    if (DATA_W == 32 && size_q == 2'd3) begin
      size_eff = 2'd2;
    end
    // Misaligned offsets are rounded down to the access size.
    ld_off   = aluout_q[OFF_W-1:0] & ({OFF_W{1'b1}} << size_eff);
    // Move the selected lane down to bit 0.
    ld_shift = load_word >> {ld_off, 3'b000};
  end

  generate
    if (DATA_W == 64) begin : g_ext64
      always_comb begin
        case (size_eff)
          2'd0:    ld_result = {{(DATA_W-8){signed_q & ld_shift[7]}},   ld_shift[7:0]};
          2'd1:    ld_result = {{(DATA_W-16){signed_q & ld_shift[15]}}, ld_shift[15:0]};
          2'd2:    ld_result = {{(DATA_W-32){signed_q & ld_shift[31]}}, ld_shift[31:0]};
          default: ld_result = ld_shift;
        endcase
      end
    end else begin : g_ext32
      always_comb begin
        case (size_eff)
          2'd0:    ld_result = {{(DATA_W-8){signed_q & ld_shift[7]}},   ld_shift[7:0]};
          2'd1:    ld_result = {{(DATA_W-16){signed_q & ld_shift[15]}}, ld_shift[15:0]};
          // Full-width word: nothing to extend, sign flag is irrelevant.
          default: ld_result = ld_shift;
        endcase
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign WaitReqW  = ((state_q == S_WAIT) && !dresp_data_ok) || (state_q == S_DRAIN);

  // A load only writes once its data is present; nothing retires in DRAIN.
  assign RegWriteW = regwrite_q && !(memtoreg_q && WaitReqW) && (state_q != S_DRAIN);

  assign ResultW   = memtoreg_q ? ld_result : aluout_q;
  assign PCW       = pc_q;
  assign WriteRegW = wreg_q;

endmodule
